refund_dispenser: RTL and testbench

Sequences the physical payout of a refund amount, in cash units, to a coin/note actuator. It sits between the refund datapath (which computes the amount owed) and the dispenser hardware. It breaks the amount into 10/5/2/1 denominations, largest first, and issues one denomination per req/ack handshake. The top-level FSM starts it, watches busy/done/error, and can abort it.

---
 rtl/refund_dispenser.sv | 210 +++++++++++++++++++++
 tb/tb_refund_dispenser.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/refund_dispenser.sv
// ============================================================================
// refund_dispenser
// ----------------------------------------------------------------------------
// Pays out a refund amount (in cash units) to a coin/note actuator. The
// amount is split greedily into 10/5/2/1 denominations, largest first, and
// one denomination is issued per four-phase req/ack handshake. Each handshake
// phase is guarded by an acknowledge timeout; a timeout parks the block in a
// sticky error state until it is aborted or reset.
//
// Ports
//   clk_i        system clock, single domain
//   rst_i        synchronous active-high reset
//   start_i      one-cycle payout request, honoured only when idle
//   abort_i      stop payout, return to idle, clear all outputs
//   amount_i     refund value 0..127, sampled with an accepted start
//   coin_ack_i   actuator acknowledge (level, already synchronised)
//   coin_req_o   dispense request (registered)
//   coin_sel_o   denomination: 0=10, 1=5, 2=2, 3=1 (registered)
//   remaining_o  units still to be paid
//   coins_out_o  coins issued in this payout, saturating at 31
//   busy_o       high while a payout is in progress
//   done_o       one-cycle pulse on payout completion
//   error_o      sticky acknowledge-timeout flag
//
// State table
//   state      | meaning
//   IDLE       | waiting for start
//   SELECT     | choose next denomination, raise coin_req
//   REQ        | coin_req high, waiting for coin_ack rise
//   RELEASE    | coin_req low, waiting for coin_ack fall
//   DONE       | one-cycle completion pulse
//   ERROR      | ack timeout; counters frozen until abort/rst
// ============================================================================
module refund_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 250_000_000,
    parameter int unsigned CNT_W       = 28
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [6:0] amount_i,
    input  logic       coin_ack_i,
    output logic       coin_req_o,
    output logic [1:0] coin_sel_o,
    output logic [6:0] remaining_o,
    output logic [4:0] coins_out_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERROR   = 3'd5;

    localparam logic [1:0] SEL_10 = 2'd0;
    localparam logic [1:0] SEL_5  = 2'd1;
    localparam logic [1:0] SEL_2  = 2'd2;
    localparam logic [1:0] SEL_1  = 2'd3;

    // The ack timer is a down-counter loaded with ACK_TIMEOUT-1 and expiring
    // on terminal count zero, so a phase may last exactly ACK_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(ACK_TIMEOUT - 32'd1);

    localparam logic [4:0] COINS_MAX = 5'd31;

    logic [2:0]       state_q,     state_d;
    logic             coin_req_q,  coin_req_d;
    logic [1:0]       coin_sel_q,  coin_sel_d;
    logic [6:0]       remaining_q, remaining_d;
    logic [4:0]       coins_q,     coins_d;
    logic [CNT_W-1:0] tmr_q,       tmr_d;

    logic             tmr_expired;

    // Largest denomination not exceeding the outstanding amount.
    function automatic logic [1:0] pick_denom(input logic [6:0] rem);
        if (rem >= 7'd10) begin
            pick_denom = SEL_10;
        end else if (rem >= 7'd5) begin
            pick_denom = SEL_5;
        end else if (rem >= 7'd2) begin
            pick_denom = SEL_2;
        end else begin
            pick_denom = SEL_1;
        end
    endfunction

    function automatic logic [6:0] denom_value(input logic [1:0] sel);
        case (sel)
            SEL_10:  denom_value = 7'd10;
            SEL_5:   denom_value = 7'd5;
            SEL_2:   denom_value = 7'd2;
            default: denom_value = 7'd1;
        endcase
    endfunction

    assign tmr_expired = (tmr_q == '0);

    always_comb begin
        state_d     = state_q;
        coin_req_d  = coin_req_q;
        coin_sel_d  = coin_sel_q;
        remaining_d = remaining_q;
        coins_d     = coins_q;
        tmr_d       = tmr_q;

        if (abort_i) begin
            // Abort outranks start and coin_ack in every state.
            state_d     = ST_IDLE;
            coin_req_d  = 1'b0;
            coin_sel_d  = 2'd0;
            remaining_d = 7'd0;
            coins_d     = 5'd0;
            tmr_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        remaining_d = amount_i;
                        coins_d     = 5'd0;
                        // A zero refund completes without touching the actuator.
                        state_d     = (amount_i != 7'd0) ? ST_SELECT : ST_DONE;
                    end
                end

                ST_SELECT: begin
                    coin_sel_d = pick_denom(remaining_q);
                    coin_req_d = 1'b1;
                    tmr_d      = TMR_LOAD;
                    state_d    = ST_REQ;
                end

                ST_REQ: begin
                    if (coin_ack_i) begin
                        // coin_sel never exceeds remaining, so no underflow.
                        coin_req_d  = 1'b0;
                        remaining_d = remaining_q - denom_value(coin_sel_q);
                        if (coins_q != COINS_MAX) begin
                            coins_d = coins_q + 5'd1;
                        end
                        tmr_d   = TMR_LOAD;
                        state_d = ST_RELEASE;
                    end else if (tmr_expired) begin
                        coin_req_d = 1'b0;
                        state_d    = ST_ERROR;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (!coin_ack_i) begin
                        state_d = (remaining_q == 7'd0) ? ST_DONE : ST_SELECT;
                    end else if (tmr_expired) begin
                        state_d = ST_ERROR;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                ST_ERROR: begin
                    // Frozen for diagnostics; only abort or rst leaves here.
                    coin_req_d = 1'b0;
                end

                default: begin
                    state_d    = ST_IDLE;
                    coin_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            coin_req_q  <= 1'b0;
            coin_sel_q  <= 2'd0;
            remaining_q <= 7'd0;
            coins_q     <= 5'd0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            coin_req_q  <= coin_req_d;
            coin_sel_q  <= coin_sel_d;
            remaining_q <= remaining_d;
            coins_q     <= coins_d;
            tmr_q       <= tmr_d;
        end
    end

    assign coin_req_o  = coin_req_q;
    assign coin_sel_o  = coin_sel_q;
    assign remaining_o = remaining_q;
    assign coins_out_o = coins_q;
    assign busy_o      = (state_q == ST_SELECT) || (state_q == ST_REQ) ||
                         (state_q == ST_RELEASE);
    assign done_o      = (state_q == ST_DONE);
    assign error_o     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_refund_dispenser.sv
// ============================================================================
// tb_refund_dispenser
// ----------------------------------------------------------------------------
// Directed bench for refund_dispenser with a short ack timeout (16 cycles).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ============================================================================
module tb_refund_dispenser;

    localparam int unsigned TO = 16;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic [6:0] amount_i;
    logic       coin_ack_i;
    logic       coin_req_o;
    logic [1:0] coin_sel_o;
    logic [6:0] remaining_o;
    logic [4:0] coins_out_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    int vec    = 0;
    int miscmp = 0;

    refund_dispenser #(
        .ACK_TIMEOUT (TO),
        .CNT_W       (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .amount_i    (amount_i),
        .coin_ack_i  (coin_ack_i),
        .coin_req_o  (coin_req_o),
        .coin_sel_o  (coin_sel_o),
        .remaining_o (remaining_o),
        .coins_out_o (coins_out_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Actuator: waits (bounded) for coin_req, acks on the next edge and drops
    // the ack one edge later. Reports what it saw; callers do the checking.
    task automatic serve_coin(output logic [1:0] sel, output logic [6:0] rem,
                              output logic req_dropped, output bit ok);
        ok = 1'b0; sel = 2'd0; rem = 7'd0; req_dropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (coin_req_o === 1'b1) break;
            tick();
        end
        if (coin_req_o !== 1'b1) return;
        ok  = 1'b1;
        sel = coin_sel_o;
        coin_ack_i = 1'b1;
        tick();
        rem = remaining_o;
        req_dropped = (coin_req_o === 1'b0);
        coin_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; amount_i = 7'd0; coin_ack_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        vec++;
        if ({coin_req_o, coin_sel_o, remaining_o, coins_out_o, busy_o, done_o, error_o} !== 18'd0) begin
            miscmp++;
            $display("FAIL reset_outputs: got %h want 0",
                     {coin_req_o, coin_sel_o, remaining_o, coins_out_o, busy_o, done_o, error_o});
        end
    endtask

    task automatic test_pay_18();
        logic [1:0] exp_sel [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [6:0] exp_rem [4] = '{7'd8, 7'd3, 7'd1, 7'd0};
        logic [1:0] sel; logic [6:0] rem; logic dropped; bit ok;
        start_i = 1'b1; amount_i = 7'd18;
        tick();
        start_i = 1'b0;
        vec++;
        if (busy_o !== 1'b1 || coin_req_o !== 1'b0) begin
            miscmp++;
            $display("FAIL p18_select_cycle: busy=%b req=%b want busy=1 req=0", busy_o, coin_req_o);
        end
        tick();
        vec++;
        if (coin_req_o !== 1'b1 || coin_sel_o !== 2'd0) begin
            miscmp++;
            $display("FAIL p18_first_req: req=%b sel=%0d want req=1 sel=0", coin_req_o, coin_sel_o);
        end
        for (int c = 0; c < 4; c++) begin
            serve_coin(sel, rem, dropped, ok);
            vec++;
            if (!ok || sel !== exp_sel[c] || rem !== exp_rem[c] || !dropped) begin
                miscmp++;
                $display("FAIL p18_coin%0d: ok=%0d sel=%0d rem=%0d drop=%b want sel=%0d rem=%0d drop=1",
                         c, ok, sel, rem, dropped, exp_sel[c], exp_rem[c]);
            end
        end
        vec++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || coins_out_o !== 5'd4) begin
            miscmp++;
            $display("FAIL p18_done: done=%b busy=%b coins=%0d want 1 0 4", done_o, busy_o, coins_out_o);
        end
        tick();
        vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            miscmp++;
            $display("FAIL p18_done_pulse_width: done=%b busy=%b want 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_zero_amount();
        start_i = 1'b1; amount_i = 7'd0;
        tick();
        start_i = 1'b0;
        vec++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || coin_req_o !== 1'b0 || coins_out_o !== 5'd0) begin
            miscmp++;
            $display("FAIL zero_done: done=%b busy=%b req=%b coins=%0d want 1 0 0 0",
                     done_o, busy_o, coin_req_o, coins_out_o);
        end
        tick();
        vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || coin_req_o !== 1'b0) begin
            miscmp++;
            $display("FAIL zero_after: done=%b busy=%b req=%b want 0 0 0", done_o, busy_o, coin_req_o);
        end
    endtask

    task automatic test_req_timeout();
        int n;
        start_i = 1'b1; amount_i = 7'd7;
        tick();
        start_i = 1'b0;
        tick();
        n = 0;
        while (coin_req_o === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        vec++;
        if (n != TO) begin
            miscmp++;
            $display("FAIL to_req_high_cycles: got %0d want %0d", n, TO);
        end
        vec++;
        if (error_o !== 1'b1 || coin_req_o !== 1'b0 || remaining_o !== 7'd7 || busy_o !== 1'b0) begin
            miscmp++;
            $display("FAIL to_error_state: err=%b req=%b rem=%0d busy=%b want 1 0 7 0",
                     error_o, coin_req_o, remaining_o, busy_o);
        end
        start_i = 1'b1; amount_i = 7'd3;
        tick();
        start_i = 1'b0;
        tick(); tick();
        vec++;
        if (error_o !== 1'b1 || busy_o !== 1'b0 || remaining_o !== 7'd7) begin
            miscmp++;
            $display("FAIL to_sticky: err=%b busy=%b rem=%0d want 1 0 7", error_o, busy_o, remaining_o);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        vec++;
        if (error_o !== 1'b0 || remaining_o !== 7'd0 || coin_sel_o !== 2'd0) begin
            miscmp++;
            $display("FAIL to_abort_clear: err=%b rem=%0d sel=%0d want 0 0 0", error_o, remaining_o, coin_sel_o);
        end
    endtask

    task automatic test_release_timeout();
        int n;
        start_i = 1'b1; amount_i = 7'd1;
        tick();
        start_i = 1'b0;
        tick();
        coin_ack_i = 1'b1;
        tick();
        n = 0;
        while (error_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        vec++;
        if (n != TO || remaining_o !== 7'd0 || coins_out_o !== 5'd1 || done_o !== 1'b0) begin
            miscmp++;
            $display("FAIL rel_timeout: cycles=%0d rem=%0d coins=%0d done=%b want %0d 0 1 0",
                     n, remaining_o, coins_out_o, done_o, TO);
        end
        coin_ack_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] sel; logic [6:0] rem; logic dropped; bit ok;
        int total, ncoins, bad;
        total = 0; ncoins = 0; bad = 0;
        start_i = 1'b1; amount_i = 7'd127;
        tick();
        start_i = 1'b0;
        tick();
        for (int c = 0; c < 14; c++) begin
            if (c == 1) begin
                start_i = 1'b1; amount_i = 7'd5;
                tick();
                start_i = 1'b0;
            end
            serve_coin(sel, rem, dropped, ok);
            if (!ok) begin
                bad++;
                break;
            end
            ncoins++;
            case (sel)
                2'd0: total += 10;
                2'd1: total += 5;
                2'd2: total += 2;
                default: total += 1;
            endcase
            if (c < 12 && sel !== 2'd0) bad++;
            if (c == 12 && sel !== 2'd1) bad++;
            if (c == 13 && sel !== 2'd2) bad++;
        end
        vec++;
        if (bad != 0 || ncoins != 14 || total != 127) begin
            miscmp++;
            $display("FAIL b2b_sequence: bad=%0d coins=%0d total=%0d want 0 14 127", bad, ncoins, total);
        end
        vec++;
        if (done_o !== 1'b1 || coins_out_o !== 5'd14 || remaining_o !== 7'd0) begin
            miscmp++;
            $display("FAIL b2b_done: done=%b coins=%0d rem=%0d want 1 14 0", done_o, coins_out_o, remaining_o);
        end
        tick();
        vec++;
        if (busy_o !== 1'b0 || coin_req_o !== 1'b0) begin
            miscmp++;
            $display("FAIL b2b_no_second_payout: busy=%b req=%b want 0 0", busy_o, coin_req_o);
        end
    endtask

    task automatic test_abort();
        int dones;
        start_i = 1'b1; amount_i = 7'd10;
        tick();
        start_i = 1'b0;
        tick();
        vec++;
        if (coin_req_o !== 1'b1) begin
            miscmp++;
            $display("FAIL abort_pre_req: req=%b want 1", coin_req_o);
        end
        abort_i = 1'b1;
        coin_ack_i = 1'b1;
        tick();
        abort_i = 1'b0;
        vec++;
        if (coin_req_o !== 1'b0 || busy_o !== 1'b0 || remaining_o !== 7'd0 || coins_out_o !== 5'd0) begin
            miscmp++;
            $display("FAIL abort_clear: req=%b busy=%b rem=%0d coins=%0d want 0 0 0 0",
                     coin_req_o, busy_o, remaining_o, coins_out_o);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) coin_ack_i = 1'b0;
            tick();
            if (done_o === 1'b1 || coin_req_o === 1'b1 || coins_out_o !== 5'd0) dones++;
        end
        vec++;
        if (dones != 0) begin
            miscmp++;
            $display("FAIL abort_late_ack: activity_cycles=%0d want 0", dones);
        end
    endtask

    task automatic test_rst_mid();
        logic [1:0] sel; logic [6:0] rem; logic dropped; bit ok;
        start_i = 1'b1; amount_i = 7'd9;
        tick();
        start_i = 1'b0;
        tick();
        coin_ack_i = 1'b1;
        tick();
        vec++;
        if (remaining_o !== 7'd4 || coins_out_o !== 5'd1) begin
            miscmp++;
            $display("FAIL rst_first_coin: rem=%0d coins=%0d want 4 1", remaining_o, coins_out_o);
        end
        rst_i = 1'b1;
        coin_ack_i = 1'b0;
        tick();
        rst_i = 1'b0;
        vec++;
        if ({coin_req_o, coin_sel_o, remaining_o, coins_out_o, busy_o, done_o, error_o} !== 18'd0) begin
            miscmp++;
            $display("FAIL rst_mid_outputs: got %h want 0",
                     {coin_req_o, coin_sel_o, remaining_o, coins_out_o, busy_o, done_o, error_o});
        end
        start_i = 1'b1; amount_i = 7'd3;
        tick();
        start_i = 1'b0;
        serve_coin(sel, rem, dropped, ok);
        vec++;
        if (!ok || sel !== 2'd2 || rem !== 7'd1) begin
            miscmp++;
            $display("FAIL rst_restart_coin0: ok=%0d sel=%0d rem=%0d want sel=2 rem=1", ok, sel, rem);
        end
        serve_coin(sel, rem, dropped, ok);
        vec++;
        if (!ok || sel !== 2'd3 || rem !== 7'd0 || done_o !== 1'b1 || coins_out_o !== 5'd2) begin
            miscmp++;
            $display("FAIL rst_restart_coin1: ok=%0d sel=%0d rem=%0d done=%b coins=%0d want 3 0 1 2",
                     ok, sel, rem, done_o, coins_out_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_pay_18();
        test_zero_amount();
        test_req_timeout();
        test_release_timeout();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
